// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, 50 MHz timing constants
// and frame geometry. Imported by the receiver, its timeout counter and the
// companion transmitter.
package ps2_pkg;

    // Receiver states
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DATA_IN   = 2'd1,
        S_PARITY_IN = 2'd2,
        S_STOP_IN   = 2'd3
    } ps2_rx_state_e;

    // 50 MHz timing constants
    localparam int unsigned CLOCK_CYCLES_FOR_2MS     = 100000;
    localparam int unsigned NUMBER_OF_BITS_FOR_2MS   = 17;
    localparam int unsigned CLOCK_CYCLES_FOR_15MS    = 750000;
    localparam int unsigned NUMBER_OF_BITS_FOR_15MS  = 20;
    localparam int unsigned CLOCK_CYCLES_FOR_101US   = 5050;
    localparam int unsigned NUMBER_OF_BITS_FOR_101US = 13;

    // Frame: start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/ps2_data_in_if.sv
// Receive-side PS/2 bus bundle.
//   slave  : seen by the receiver (strobes/data in, byte and status pulses out)
//   master : seen by whoever drives the strobes and consumes the bytes
interface ps2_data_in_if;

    logic       receive_enable;
    logic       ps2_clk_posedge;
    logic       ps2_clk_negedge;
    logic       ps2_data;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       parity_error;
    logic       framing_error;
    logic       timeout_error;

    modport slave (
        input  receive_enable, ps2_clk_posedge, ps2_clk_negedge, ps2_data,
        output received_data, received_data_en, parity_error, framing_error,
               timeout_error
    );

    modport master (
        output receive_enable, ps2_clk_posedge, ps2_clk_negedge, ps2_data,
        input  received_data, received_data_en, parity_error, framing_error,
               timeout_error
    );

endinterface

// File: rtl/ps2_timeout_counter.sv
// Saturating cycle counter with a hit flag at LIMIT.
//   clk, reset : clock, async active-high reset
//   clear      : force count to 0 (wins over enable)
//   enable     : count up by one per cycle, stopping at LIMIT
//   hit_c      : count has reached LIMIT
module ps2_timeout_counter #(
    parameter int unsigned LIMIT = 100000,
    parameter int unsigned WIDTH = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit_c
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, else saturating increment
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != WIDTH'(LIMIT))) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_c = (count_q == WIDTH'(LIMIT));

endmodule

// File: rtl/ps2_data_in.sv
// PS/2 device-to-host frame receiver. Samples ps2_data on each falling-edge
// strobe, assembles start/8 data LSB-first/odd parity/stop and reports each
// frame with exactly one registered pulse: byte, parity, framing or timeout.
//   clk, reset : clock, async active-high reset
//   bus        : ps2_data_in_if.slave (enable, edge strobes, data, results)
module ps2_data_in
    import ps2_pkg::*;
#(
    parameter int unsigned CLOCK_CYCLES_FOR_2MS   = ps2_pkg::CLOCK_CYCLES_FOR_2MS,
    parameter int unsigned NUMBER_OF_BITS_FOR_2MS = ps2_pkg::NUMBER_OF_BITS_FOR_2MS
) (
    input  logic           clk,
    input  logic           reset,
    ps2_data_in_if.slave   bus
);

    ps2_rx_state_e state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic          parity_q, parity_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_en_q, rx_en_d;
    logic          par_err_q, par_err_d;
    logic          frm_err_q, frm_err_d;
    logic          tmo_err_q, tmo_err_d;
    logic          tmo_hit_c;
    logic          unused_posedge_c;

    // Rising-edge strobe is reserved; kept on the bus for the paired transmitter
    assign unused_posedge_c = bus.ps2_clk_posedge;

    // Whole-frame timer: idle keeps it cleared, so it restarts at every start bit
    ps2_timeout_counter #(
        .LIMIT (CLOCK_CYCLES_FOR_2MS),
        .WIDTH (NUMBER_OF_BITS_FOR_2MS)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == S_IDLE),
        .enable (state_q != S_IDLE),
        .hit_c  (tmo_hit_c)
    );

    // Next state / outputs; a negedge beats a timeout, disable beats both
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        rx_data_d = rx_data_q;
        rx_en_d   = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        tmo_err_d = 1'b0;

        if (!bus.receive_enable) begin
            state_d   = S_IDLE;
            bit_idx_d = 4'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.ps2_clk_negedge && !bus.ps2_data) begin
                        state_d   = S_DATA_IN;
                        bit_idx_d = 4'd0;
                    end
                end
                S_DATA_IN: begin
                    if (bus.ps2_clk_negedge) begin
                        shift_d[bit_idx_q[2:0]] = bus.ps2_data;
                        bit_idx_d = bit_idx_q + 4'd1;
                        if (bit_idx_q == 4'd7) begin
                            state_d = S_PARITY_IN;
                        end
                    end else if (tmo_hit_c) begin
                        state_d   = S_IDLE;
                        tmo_err_d = 1'b1;
                    end
                end
                S_PARITY_IN: begin
                    if (bus.ps2_clk_negedge) begin
                        parity_d = bus.ps2_data;
                        state_d  = S_STOP_IN;
                    end else if (tmo_hit_c) begin
                        state_d   = S_IDLE;
                        tmo_err_d = 1'b1;
                    end
                end
                S_STOP_IN: begin
                    if (bus.ps2_clk_negedge) begin
                        state_d = S_IDLE;
                        if (!bus.ps2_data) begin
                            frm_err_d = 1'b1;
                        end else if (^{parity_q, shift_q} == 1'b0) begin
                            par_err_d = 1'b1;
                        end else begin
                            rx_data_d = shift_q;
                            rx_en_d   = 1'b1;
                        end
                    end else if (tmo_hit_c) begin
                        state_d   = S_IDLE;
                        tmo_err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'h00;
            bit_idx_q <= 4'd0;
            parity_q  <= 1'b0;
            rx_data_q <= 8'h00;
            rx_en_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            rx_data_q <= rx_data_d;
            rx_en_q   <= rx_en_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign bus.received_data    = rx_data_q;
    assign bus.received_data_en = rx_en_q;
    assign bus.parity_error     = par_err_q;
    assign bus.framing_error    = frm_err_q;
    assign bus.timeout_error    = tmo_err_q;

endmodule

// File: tb/tb_ps2_data_in.sv
// Scoreboard bench for ps2_data_in: expected pulses are queued when the
// stimulus that should cause them is driven and retired by a monitor.
module tb_ps2_data_in;

    localparam int unsigned LIM = 300;
    localparam int unsigned W   = 9;
    localparam int unsigned GAP = 3;

    // Pulse codes {timeout, framing, parity, data}
    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_DATA = 4'b0001;
    localparam logic [3:0] K_PAR  = 4'b0010;
    localparam logic [3:0] K_FRM  = 4'b0100;
    localparam logic [3:0] K_TMO  = 4'b1000;

    typedef struct {
        logic [3:0]  code;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    exp_t        sb[$];

    ps2_data_in_if bus ();

    ps2_data_in #(
        .CLOCK_CYCLES_FOR_2MS   (LIM),
        .NUMBER_OF_BITS_FOR_2MS (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest expectation, in kind and cycle
    always @(negedge clk) begin
        logic [3:0] obs;
        exp_t       e;
        obs = {bus.timeout_error, bus.framing_error, bus.parity_error, bus.received_data_en};
        if (!reset && obs != K_NONE) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(obs), 32'(K_NONE));
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 32'(obs), 32'(e.code));
                check("pulse_cycle", cyc, e.cyc);
                if (e.code == K_DATA) check("rx_byte", 32'(bus.received_data), 32'(e.data));
            end
        end
    end

    // One falling-edge strobe; an expectation is queued at the moment it is raised
    task automatic strobe(input logic b, input logic [3:0] code, input logic [7:0] d,
                          input int unsigned lat);
        exp_t e;
        @(posedge clk); #1;
        bus.ps2_data        = b;
        bus.ps2_clk_negedge = 1'b1;
        if (code != K_NONE) begin
            e.code = code; e.data = d; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.ps2_clk_negedge = 1'b0;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d, input int unsigned n);
        strobe(1'b0, K_NONE, 8'h00, 0);
        for (int i = 0; i < int'(n); i++) strobe(d[i], K_NONE, 8'h00, 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic [3:0] code);
        send_bits(d, 8);
        strobe(par, K_NONE, 8'h00, 0);
        strobe(stop, code, d, 1);
    endtask

    task automatic drain(input int unsigned budget);
        for (int i = 0; i < int'(budget) && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("sb_drain", sb.size(), 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_data"}, 32'(bus.received_data), 32'h0);
        check({tag, "_strobes"}, 32'({bus.timeout_error, bus.framing_error,
                                      bus.parity_error, bus.received_data_en}), 32'h0);
    endtask

    initial begin
        logic [7:0] rb;
        bus.receive_enable  = 1'b1;
        bus.ps2_clk_posedge = 1'b0;
        bus.ps2_clk_negedge = 1'b0;
        bus.ps2_data        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Good 0xFA acknowledge
        send_frame(8'hFA, 1'b1, 1'b1, K_DATA);
        drain(20);

        // Same byte, wrong parity: error only, byte held
        send_frame(8'hFA, 1'b0, 1'b1, K_PAR);
        drain(20);
        check("hold_after_parity", 32'(bus.received_data), 32'hFA);

        // Stop bit 0, then a good frame immediately after
        send_frame(8'h1C, 1'b0, 1'b0, K_FRM);
        check("hold_after_framing", 32'(bus.received_data), 32'hFA);
        send_frame(8'h1C, 1'b0, 1'b1, K_DATA);
        drain(20);

        // Start bit then silence: timeout LIM+1 cycles after the sampling edge
        strobe(1'b0, K_TMO, 8'h00, 1 + LIM + 1);
        drain(LIM + 50);
        check("hold_after_timeout", 32'(bus.received_data), 32'h1C);
        // Counter must have been cleared: a full frame fits easily within LIM
        send_frame(8'h3B, 1'b0, 1'b1, K_DATA);
        drain(20);

        // Enable dropped after 4 data bits: silent abort, then 0xAA
        send_bits(8'h0F, 4);
        @(posedge clk); #1;
        bus.receive_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.receive_enable = 1'b1;
        send_frame(8'hAA, 1'b1, 1'b1, K_DATA);
        drain(20);

        // Reset after 6 data bits: outputs clear immediately
        send_bits(8'h15, 6);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_cleared("midreset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        // Idle negedges with data high must not start a frame
        for (int i = 0; i < 3; i++) strobe(1'b1, K_NONE, 8'h00, 0);
        repeat (LIM + 20) @(posedge clk);
        check("idle_no_activity", sb.size(), 0);
        send_frame(8'h5A, 1'b1, 1'b1, K_DATA);
        drain(20);

        // A few random good bytes back to back
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, ~^rb, 1'b1, K_DATA);
        end
        drain(20);
        check("final_byte_held", 32'(bus.received_data), 32'(rb));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
